// File: rtl/gl_prim_pkg.sv
// gl_prim_pkg: shared definitions for the primitive assembly stage.
//   - primitive mode encodings (points, lines, triangles, triangle strip)
//   - attribute index constants for the six vertex attributes
//   - eff_mode(): maps the latched mode onto the mode that is actually built
// Configuration macro: GL_STRIP_EN. When it is undefined, strip mode folds
// onto independent triangles.
package gl_prim_pkg;

    typedef enum logic [1:0] {
        GL_PRIM_POINTS = 2'd0,
        GL_PRIM_LINES  = 2'd1,
        GL_PRIM_TRIS   = 2'd2,
        GL_PRIM_STRIP  = 2'd3
    } gl_prim_mode_e;

    // Attribute 0 sits at the MSBs of a packed vertex.
    localparam int ATTR_X = 0;
    localparam int ATTR_Y = 1;
    localparam int ATTR_Z = 2;
    localparam int ATTR_R = 3;
    localparam int ATTR_G = 4;
    localparam int ATTR_B = 5;

    function automatic gl_prim_mode_e eff_mode(input logic [1:0] m);
`ifdef GL_STRIP_EN
        return gl_prim_mode_e'(m);
`else
        // Without strip support, mode 3 assembles independent triangles.
        return (m == 2'd3) ? GL_PRIM_TRIS : gl_prim_mode_e'(m);
`endif
    endfunction

endpackage

// File: rtl/gl_sync_fifo.sv
// gl_sync_fifo: single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointers/level only)
//   wr_en, din  - write request and data; ignored when full unless rd_en
//   rd_en       - pop the head; ignored when empty
//   dout        - head word, read straight from the storage registers
//   full, empty - occupancy flags
//   level       - current occupancy, 0..DEPTH
module gl_sync_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             wr_ok, rd_ok;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A write while full is only legal together with a read of the head.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/gl_prim_assembler.sv
// gl_prim_assembler: queues post-viewport vertices and groups them into
// points, lines, independent triangles or triangle strips, one complete
// primitive per output handshake.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   mode, begin_prim        - batch mode, latched when begin_prim is accepted
//   busy                    - FIFO non-empty or a primitive is pending
//   vert_valid/ready/data   - vertex input handshake
//   prim_valid/ready/data   - primitive output handshake, {v0,v1,v2}
//   prim_count              - vertices in prim_data (1..3)
//   fifo_level              - vertex FIFO occupancy
// Configuration macro: GL_STRIP_EN enables triangle-strip assembly with
// winding alternation; otherwise mode 3 behaves as independent triangles.
module gl_prim_assembler
    import gl_prim_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_ATTR = 6,
    parameter int DEPTH    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      mode,
    input  logic                            begin_prim,
    output logic                            busy,
    input  logic                            vert_valid,
    output logic                            vert_ready,
    input  logic [NUM_ATTR*DATA_W-1:0]      vert_data,
    output logic                            prim_valid,
    input  logic                            prim_ready,
    output logic [3*NUM_ATTR*DATA_W-1:0]    prim_data,
    output logic [1:0]                      prim_count,
    output logic [$clog2(DEPTH):0]          fifo_level
);

    localparam int VW = NUM_ATTR * DATA_W;

    logic [VW-1:0]   fifo_dout;
    logic            fifo_full, fifo_empty;
    logic            wr_en, pop, completes, begin_acc;

    gl_prim_mode_e   mode_q, mode_d, em;
    logic [1:0]      cnt_q, cnt_d;
    logic [VW-1:0]   s0_q, s0_d, s1_q, s1_d;
    logic            pv_q, pv_d;
    logic [3*VW-1:0] pd_q, pd_d;
    logic [1:0]      pc_q, pc_d;
`ifdef GL_STRIP_EN
    logic            par_q, par_d;
`endif

    gl_sync_fifo #(.WIDTH(VW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .rd_en (pop),
        .din   (vert_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // vert_ready depends only on registered FIFO state, never on prim_ready.
    assign vert_ready = !reset && !fifo_full;
    assign wr_en      = vert_valid && vert_ready;
    assign busy       = !fifo_empty || pv_q;
    assign begin_acc  = begin_prim && !busy;
    assign em         = eff_mode(mode_q);

    assign prim_valid = pv_q;
    assign prim_data  = pd_q;
    assign prim_count = pc_q;

    // A vertex that only fills a slot can always be popped; one that closes
    // a primitive needs the output register free or draining this cycle.
    always_comb begin
        completes = 1'b0;
        case (em)
            GL_PRIM_POINTS: completes = 1'b1;
            GL_PRIM_LINES:  completes = (cnt_q == 2'd1);
            default:        completes = (cnt_q == 2'd2);
        endcase
        pop = !fifo_empty && (!completes || !pv_q || prim_ready);
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        pv_d   = pv_q;
        pd_d   = pd_q;
        pc_d   = pc_q;
`ifdef GL_STRIP_EN
        par_d  = par_q;
`endif
        // begin_acc implies an empty FIFO, so it never coincides with a pop.
        if (begin_acc) begin
            mode_d = gl_prim_mode_e'(mode);
            cnt_d  = 2'd0;
`ifdef GL_STRIP_EN
            par_d  = 1'b0;
`endif
        end

        if (pv_q && prim_ready) pv_d = 1'b0;

        if (pop) begin
            case (em)
                GL_PRIM_POINTS: begin
                    pv_d = 1'b1;
                    pd_d = {fifo_dout, {VW{1'b0}}, {VW{1'b0}}};
                    pc_d = 2'd1;
                end
                GL_PRIM_LINES: begin
                    if (cnt_q == 2'd0) begin
                        s0_d  = fifo_dout;
                        cnt_d = 2'd1;
                    end else begin
                        pv_d  = 1'b1;
                        pd_d  = {s0_q, fifo_dout, {VW{1'b0}}};
                        pc_d  = 2'd2;
                        cnt_d = 2'd0;
                    end
                end
`ifdef GL_STRIP_EN
                GL_PRIM_STRIP: begin
                    if (cnt_q == 2'd0) begin
                        s0_d  = fifo_dout;
                        cnt_d = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        s1_d  = fifo_dout;
                        cnt_d = 2'd2;
                    end else begin
                        // Odd triangles swap the first two vertices so every
                        // triangle keeps the winding of the first one.
                        pv_d  = 1'b1;
                        pd_d  = par_q ? {s1_q, s0_q, fifo_dout}
                                      : {s0_q, s1_q, fifo_dout};
                        pc_d  = 2'd3;
                        s0_d  = s1_q;
                        s1_d  = fifo_dout;
                        par_d = ~par_q;
                    end
                end
`endif
                default: begin
                    if (cnt_q == 2'd0) begin
                        s0_d  = fifo_dout;
                        cnt_d = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        s1_d  = fifo_dout;
                        cnt_d = 2'd2;
                    end else begin
                        pv_d  = 1'b1;
                        pd_d  = {s0_q, s1_q, fifo_dout};
                        pc_d  = 2'd3;
                        cnt_d = 2'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= GL_PRIM_POINTS;
            cnt_q  <= 2'd0;
            pv_q   <= 1'b0;
            pd_q   <= '0;
            pc_q   <= 2'd0;
`ifdef GL_STRIP_EN
            par_q  <= 1'b0;
`endif
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pv_q   <= pv_d;
            pd_q   <= pd_d;
            pc_q   <= pc_d;
`ifdef GL_STRIP_EN
            par_q  <= par_d;
`endif
        end
    end

    // Slot contents are qualified by cnt_q, so they need no reset.
    always_ff @(posedge clk) begin
        s0_q <= s0_d;
        s1_q <= s1_d;
    end

endmodule

// File: tb/tb_gl_prim_assembler.sv
module tb_gl_prim_assembler;
    import gl_prim_pkg::*;

    localparam int DATA_W   = 32;
    localparam int NUM_ATTR = 6;
    localparam int DEPTH    = 8;
    localparam int VW       = NUM_ATTR * DATA_W;
    localparam int PW       = 3 * VW;

    logic                   clk;
    logic                   reset;
    logic [1:0]             mode;
    logic                   begin_prim;
    logic                   busy;
    logic                   vert_valid;
    logic                   vert_ready;
    logic [VW-1:0]          vert_data;
    logic                   prim_valid;
    logic                   prim_ready;
    logic [PW-1:0]          prim_data;
    logic [1:0]             prim_count;
    logic [$clog2(DEPTH):0] fifo_level;

    gl_prim_assembler #(.DATA_W(DATA_W), .NUM_ATTR(NUM_ATTR), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .begin_prim (begin_prim),
        .busy       (busy),
        .vert_valid (vert_valid),
        .vert_ready (vert_ready),
        .vert_data  (vert_data),
        .prim_valid (prim_valid),
        .prim_ready (prim_ready),
        .prim_data  (prim_data),
        .prim_count (prim_count),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        logic [1:0]    cnt;
    } prim_t;

    prim_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    run_len  = 0;
    int    max_run  = 0;

    localparam logic [VW-1:0] ZV = '0;

    // Vertex id -> six attributes: attr k = id*256 + k, attr 0 at the MSBs.
    function automatic logic [VW-1:0] vtx(input int id);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_ATTR; k++)
            v[(NUM_ATTR-1-k)*DATA_W +: DATA_W] = 32'(id * 256 + k);
        return v;
    endfunction

    task automatic push_prim(input logic [VW-1:0] a, input logic [VW-1:0] b,
                             input logic [VW-1:0] c, input logic [1:0] n);
        prim_t p;
        p.data = {a, b, c};
        p.cnt  = n;
        exp_q.push_back(p);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake is compared with the queue head.
    always @(negedge clk) begin
        if (!reset && prim_valid && prim_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL prim_unexpected actual count=%0d data=%0h required none",
                         prim_count, prim_data);
            end else begin
                prim_t e;
                e = exp_q.pop_front();
                if (prim_data !== e.data || prim_count !== e.cnt) begin
                    failures++;
                    $display("FAIL prim_out actual count=%0d data=%0h required count=%0d data=%0h",
                             prim_count, prim_data, e.cnt, e.data);
                end
            end
        end
        if (prim_valid) run_len++;
        else            run_len = 0;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic send_vert(input int id);
        bit ok;
        ok = 0;
        vert_valid = 1'b1;
        vert_data  = vtx(id);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vert_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL send_timeout actual vert_ready=0 required 1 (vertex %0d)", id);
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_batch(input logic [1:0] m);
        begin_prim = 1'b1;
        mode       = m;
        @(posedge clk);
        #1;
        begin_prim = 1'b0;
        mode       = ~m;   // mode must only matter on the begin_prim cycle
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check(name, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        bit acc;

        reset      = 1'b1;
        mode       = 2'd0;
        begin_prim = 1'b0;
        vert_valid = 1'b0;
        vert_data  = '0;
        prim_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_vert_ready", 64'(vert_ready), 64'(0));
        check("rst_prim_valid", 64'(prim_valid), 64'(0));
        check("rst_prim_data",  64'(|prim_data), 64'(0));
        check("rst_prim_count", 64'(prim_count), 64'(0));
        check("rst_fifo_level", 64'(fifo_level), 64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_vert_ready", 64'(vert_ready), 64'(1));

        // Triangles: one {A,B,C}, prim_valid two cycles after C is accepted
        prim_ready = 1'b1;
        begin_batch(GL_PRIM_TRIS);
        push_prim(vtx(1), vtx(2), vtx(3), 2'd3);
        send_vert(1);
        send_vert(2);
        send_vert(3);
        vert_valid = 1'b0;
        @(negedge clk);
        check("tri_latency_n1", 64'(prim_valid), 64'(0));
        @(negedge clk);
        check("tri_latency_n2", 64'(prim_valid), 64'(1));
        @(posedge clk);
        #1;
        drain("tri_drain");

        // Points: four primitives on consecutive cycles
        begin_batch(GL_PRIM_POINTS);
        max_run = 0;
        for (int i = 10; i < 14; i++) push_prim(vtx(i), ZV, ZV, 2'd1);
        for (int i = 10; i < 14; i++) send_vert(i);
        vert_valid = 1'b0;
        drain("pts_drain");
        check("pts_back_to_back", 64'(max_run), 64'(4));

        // Strip A..E
        begin_batch(GL_PRIM_STRIP);
        push_prim(vtx(20), vtx(21), vtx(22), 2'd3);
`ifdef GL_STRIP_EN
        push_prim(vtx(22), vtx(21), vtx(23), 2'd3);
        push_prim(vtx(22), vtx(23), vtx(24), 2'd3);
`endif
        for (int i = 20; i < 25; i++) send_vert(i);
        vert_valid = 1'b0;
        drain("strip_drain");

        // Back-pressure: lines, prim_ready low, 12 vertices offered
        begin_batch(GL_PRIM_LINES);
        prim_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_prim(vtx(100 + 2*i), vtx(101 + 2*i), ZV, 2'd2);
        idx        = 0;
        vert_valid = 1'b1;
        vert_data  = vtx(100);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = vert_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 12) vert_data = vtx(100 + idx);
                else          vert_valid = 1'b0;
            end
        end
        check("bp_accepted",   64'(idx),        64'(11));
        check("bp_vert_ready", 64'(vert_ready), 64'(0));
        check("bp_fifo_level", 64'(fifo_level), 64'(8));
        check("bp_prim_valid", 64'(prim_valid), 64'(1));
        check("bp_prim_count", 64'(prim_count), 64'(2));
        prim_ready = 1'b1;
        for (int c = 0; c < 100 && idx < 12; c++) begin
            @(negedge clk);
            acc = vert_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        vert_valid = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'(12));
        drain("bp_drain");

        // Batch restart: partial triangle discarded by an idle begin_prim
        begin_batch(GL_PRIM_TRIS);
        send_vert(200);
        send_vert(201);
        vert_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("restart_idle", 64'(busy), 64'(0));
        begin_batch(GL_PRIM_POINTS);
        push_prim(vtx(202), ZV, ZV, 2'd1);
        send_vert(202);
        vert_valid = 1'b0;
        drain("restart_drain");

        // begin_prim while busy is ignored
        prim_ready = 1'b0;
        push_prim(vtx(203), ZV, ZV, 2'd1);
        push_prim(vtx(204), ZV, ZV, 2'd1);
        send_vert(203);
        vert_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ignore_busy", 64'(busy), 64'(1));
        begin_batch(GL_PRIM_LINES);
        send_vert(204);
        vert_valid = 1'b0;
        prim_ready = 1'b1;
        drain("ignore_drain");

        // Reset mid-stream
        begin_batch(GL_PRIM_LINES);
        prim_ready = 1'b0;
        for (int i = 300; i < 308; i++) send_vert(i);
        vert_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_fifo_level", 64'(fifo_level), 64'(5));
        check("mid_prim_valid", 64'(prim_valid), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_prim_valid", 64'(prim_valid), 64'(0));
        check("mid_rst_fifo_level", 64'(fifo_level), 64'(0));
        check("mid_rst_busy",       64'(busy),       64'(0));
        check("mid_rst_vert_ready", 64'(vert_ready), 64'(0));
        reset      = 1'b0;
        prim_ready = 1'b1;
        @(posedge clk);
        #1;
        push_prim(vtx(308), ZV, ZV, 2'd1);
        send_vert(308);
        vert_valid = 1'b0;
        drain("mid_rst_points");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
